// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake.
// SKID=1: two-entry skid buffer with a registered in_ready (no out_ready->in_ready path).
// SKID=0: single entry, in_ready is combinational from out_ready.
// out_ctrl is held at all-zero whenever out_valid is low, so bubbles never assert controls.
// Bubble and stall performance counters saturate and survive flush.
module pipe_stage_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Saturating increment shared by both performance counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Main entry: drives the out_* bundle in both modes
    logic              out_valid_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    assign out_valid  = out_valid_r;
    assign out_ctrl   = main_ctrl_r;
    assign out_data   = main_data_r;
    assign bubble_cnt = bubble_cnt_r;
    assign stall_cnt  = stall_cnt_r;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                TWO   = 2'd2
            } state_t;

            state_t            state_r;
            logic              in_ready_r;
            logic [CTRL_W-1:0] skid_ctrl_r;
            logic [DATA_W-1:0] skid_data_r;
            logic              in_xfer_s;
            logic              out_xfer_s;

            assign in_ready   = in_ready_r;
            assign in_xfer_s  = in_valid & in_ready_r;
            assign out_xfer_s = out_valid_r & out_ready;

            // Skid FSM: reset beats flush beats transfers; in_ready follows next state
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                    main_ctrl_r <= {CTRL_W{1'b0}};
                    in_ready_r  <= 1'b1;
                end else begin
                    case (state_r)
                        EMPTY: begin
                            if (in_xfer_s) begin
                                main_ctrl_r <= in_ctrl;
                                main_data_r <= in_data;
                                out_valid_r <= 1'b1;
                                state_r     <= ONE;
                            end else begin
                                state_r     <= EMPTY;
                            end
                            in_ready_r <= 1'b1;
                        end
                        ONE: begin
                            case ({in_xfer_s, out_xfer_s})
                                2'b10: begin
                                    // Downstream stalled: park the new entry in skid
                                    skid_ctrl_r <= in_ctrl;
                                    skid_data_r <= in_data;
                                    state_r     <= TWO;
                                    in_ready_r  <= 1'b0;
                                end
                                2'b01: begin
                                    out_valid_r <= 1'b0;
                                    main_ctrl_r <= {CTRL_W{1'b0}};
                                    state_r     <= EMPTY;
                                    in_ready_r  <= 1'b1;
                                end
                                2'b11: begin
                                    main_ctrl_r <= in_ctrl;
                                    main_data_r <= in_data;
                                    state_r     <= ONE;
                                    in_ready_r  <= 1'b1;
                                end
                                default: begin
                                    state_r    <= ONE;
                                    in_ready_r <= 1'b1;
                                end
                            endcase
                        end
                        TWO: begin
                            if (out_xfer_s) begin
                                main_ctrl_r <= skid_ctrl_r;
                                main_data_r <= skid_data_r;
                                state_r     <= ONE;
                                in_ready_r  <= 1'b1;
                            end else begin
                                state_r     <= TWO;
                                in_ready_r  <= 1'b0;
                            end
                        end
                        default: begin
                            state_r     <= EMPTY;
                            out_valid_r <= 1'b0;
                            main_ctrl_r <= {CTRL_W{1'b0}};
                            in_ready_r  <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic in_xfer_s;
            logic out_xfer_s;

            assign in_ready   = out_ready | ~out_valid_r;
            assign in_xfer_s  = in_valid & in_ready;
            assign out_xfer_s = out_valid_r & out_ready;

            // Single entry: load on input transfer, empty on output-only transfer
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    out_valid_r <= 1'b0;
                    main_ctrl_r <= {CTRL_W{1'b0}};
                end else if (in_xfer_s) begin
                    out_valid_r <= 1'b1;
                    main_ctrl_r <= in_ctrl;
                    main_data_r <= in_data;
                end else if (out_xfer_s) begin
                    out_valid_r <= 1'b0;
                    main_ctrl_r <= {CTRL_W{1'b0}};
                end else begin
                    out_valid_r <= out_valid_r;
                end
            end
        end
    endgenerate

    // Performance counters: count the current cycle's output condition, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (!out_valid_r) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (out_valid_r && !out_ready) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, single-entry mode and a narrow-counter copy.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush;
    // Shared stimulus for the skid instance and the narrow-counter instance
    logic        in_valid, out_ready;
    logic [2:0]  in_ctrl;
    logic [31:0] in_data;
    // Stimulus for the single-entry instance
    logic        in_valid0, out_ready0;
    logic [2:0]  in_ctrl0;
    logic [31:0] in_data0;

    logic        in_ready1, out_valid1;
    logic [2:0]  out_ctrl1;
    logic [31:0] out_data1;
    logic [15:0] bubble1, stall1;

    logic        in_readyc, out_validc;
    logic [2:0]  out_ctrlc;
    logic [31:0] out_datac;
    logic [3:0]  bubblec, stallc;

    logic        in_ready0, out_valid0;
    logic [2:0]  out_ctrl0;
    logic [31:0] out_data0;
    logic [15:0] bubble0, stall0;

    pipe_stage_reg #(.CTRL_W(3), .DATA_W(32), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .bubble_cnt(bubble1), .stall_cnt(stall1)
    );

    pipe_stage_reg #(.CTRL_W(3), .DATA_W(32), .SKID(1), .CNT_W(4)) dutc (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_readyc), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_validc), .out_ready(out_ready), .out_ctrl(out_ctrlc), .out_data(out_datac),
        .bubble_cnt(bubblec), .stall_cnt(stallc)
    );

    pipe_stage_reg #(.CTRL_W(3), .DATA_W(32), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .bubble_cnt(bubble0), .stall_cnt(stall0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push1(input logic [31:0] d, input logic [2:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_ctrl = 3'd0; in_data = 32'd0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; in_ctrl0 = 3'd0; in_data0 = 32'd0;

        // Reset state
        do_reset();
        check_val("rst_out_valid", out_valid1, 1'b0);
        check_val("rst_out_ctrl",  out_ctrl1, 3'b000);
        check_val("rst_bubble",    bubble1, 16'd0);
        check_val("rst_stall",     stall1, 16'd0);
        check_val("rst_in_ready",  in_ready1, 1'b1);
        check_val("rst_in_ready0", in_ready0, 1'b1);

        // Idle counting: 4-bit counter saturates at 15
        for (int i = 0; i < 15; i++) step();
        check_val("sat_bubblec_15", bubblec, 4'd15);
        for (int i = 0; i < 5; i++) step();
        check_val("sat_bubblec_hold", bubblec, 4'd15);
        check_val("idle_bubble1_20", bubble1, 16'd20);
        check_val("idle_stall1", stall1, 16'd0);

        // Streaming 1..8 with out_ready high
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push1(i, i[2:0]);
            step();
            check_val($sformatf("strm_data_%0d", i), out_data1, i);
            check_val($sformatf("strm_ctrl_%0d", i), out_ctrl1, i[2:0]);
            check_val($sformatf("strm_valid_%0d", i), out_valid1, 1'b1);
            check_val($sformatf("strm_rdy_%0d", i), in_ready1, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check_val("strm_end_valid", out_valid1, 1'b0);
        check_val("strm_end_ctrl",  out_ctrl1, 3'b000);
        check_val("strm_bubble",    bubble1, 16'd1);
        check_val("strm_stall",     stall1, 16'd0);

        // Fill to TWO under stall, then drain
        do_reset();
        out_ready = 1'b0;
        push1(32'hA, 3'b001);
        step();
        check_val("skid_one_valid", out_valid1, 1'b1);
        check_val("skid_one_data",  out_data1, 32'hA);
        check_val("skid_one_rdy",   in_ready1, 1'b1);
        push1(32'hB, 3'b010);
        step();
        in_valid = 1'b0;
        check_val("skid_two_rdy",   in_ready1, 1'b0);
        check_val("skid_two_data",  out_data1, 32'hA);
        check_val("skid_two_stall", stall1, 16'd1);
        step();
        step();
        check_val("skid_hold_data", out_data1, 32'hA);
        check_val("skid_hold_ctrl", out_ctrl1, 3'b001);
        check_val("skid_hold_stall", stall1, 16'd3);
        check_val("skid_hold_rdy",  in_ready1, 1'b0);
        out_ready = 1'b1;
        step();
        check_val("drain_b_data",  out_data1, 32'hB);
        check_val("drain_b_ctrl",  out_ctrl1, 3'b010);
        check_val("drain_b_valid", out_valid1, 1'b1);
        check_val("drain_b_rdy",   in_ready1, 1'b1);
        step();
        check_val("drain_empty_valid", out_valid1, 1'b0);
        check_val("drain_empty_ctrl",  out_ctrl1, 3'b000);
        check_val("drain_stall",       stall1, 16'd3);

        // Flush while in TWO with a simultaneous offered input
        do_reset();
        out_ready = 1'b0;
        push1(32'hA, 3'b001);
        step();
        push1(32'hB, 3'b010);
        step();
        check_val("fl_pre_rdy", in_ready1, 1'b0);
        flush = 1'b1;
        push1(32'hF, 3'b111);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("fl_valid",  out_valid1, 1'b0);
        check_val("fl_ctrl",   out_ctrl1, 3'b000);
        check_val("fl_rdy",    in_ready1, 1'b1);
        check_val("fl_stall",  stall1, 16'd2);
        check_val("fl_bubble", bubble1, 16'd1);
        step();
        check_val("fl_drop_valid", out_valid1, 1'b0);
        check_val("fl_drop_bubble", bubble1, 16'd2);

        // Reset while in TWO, then restart
        do_reset();
        out_ready = 1'b0;
        push1(32'h11, 3'b011);
        step();
        push1(32'h12, 3'b101);
        step();
        check_val("rt_pre_rdy", in_ready1, 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        check_val("rt_valid",  out_valid1, 1'b0);
        check_val("rt_ctrl",   out_ctrl1, 3'b000);
        check_val("rt_bubble", bubble1, 16'd0);
        check_val("rt_stall",  stall1, 16'd0);
        check_val("rt_rdy",    in_ready1, 1'b1);
        out_ready = 1'b1;
        push1(32'h21, 3'b100);
        step();
        check_val("rt_data1", out_data1, 32'h21);
        push1(32'h22, 3'b110);
        step();
        in_valid = 1'b0;
        check_val("rt_data2", out_data1, 32'h22);
        check_val("rt_ctrl2", out_ctrl1, 3'b110);
        step();
        check_val("rt_end_valid", out_valid1, 1'b0);

        // Single-entry mode with out_ready toggling 1,0,1
        do_reset();
        in_valid0 = 1'b1; in_data0 = 32'h51; in_ctrl0 = 3'b001; out_ready0 = 1'b1;
        #1;
        check_val("s0_empty_rdy", in_ready0, 1'b1);
        step();
        check_val("s0_d51", out_data0, 32'h51);
        check_val("s0_v51", out_valid0, 1'b1);
        in_data0 = 32'h52; in_ctrl0 = 3'b010;
        #1;
        check_val("s0_rdy_hi", in_ready0, 1'b1);
        step();
        check_val("s0_d52", out_data0, 32'h52);
        in_data0 = 32'h53; in_ctrl0 = 3'b011; out_ready0 = 1'b0;
        #1;
        check_val("s0_rdy_lo", in_ready0, 1'b0);
        step();
        check_val("s0_hold_d", out_data0, 32'h52);
        check_val("s0_hold_c", out_ctrl0, 3'b010);
        out_ready0 = 1'b1;
        #1;
        check_val("s0_rdy_hi2", in_ready0, 1'b1);
        step();
        check_val("s0_d53", out_data0, 32'h53);
        check_val("s0_c53", out_ctrl0, 3'b011);
        in_valid0 = 1'b0;
        step();
        check_val("s0_end_valid", out_valid0, 1'b0);
        check_val("s0_end_ctrl",  out_ctrl0, 3'b000);
        check_val("s0_stall",     stall0, 16'd1);
        check_val("s0_bubble",    bubble0, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter CTRL_W, default 3, width of the control bundle (e.g. PCSrc/RegWrite/MemtoReg).
REQ-002 SHALL provide parameter DATA_W, default 32, width of the data bundle (e.g. ALU result/read data).
REQ-003 SHALL provide parameter SKID, default 1; 0 selects single-entry mode, 1 selects two-entry skid mode.
REQ-004 SHALL provide parameter CNT_W, default 16, width of each performance counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 flush  input  1  discard every held entry.
REQ-009 in_valid  input  1  upstream entry offered.
REQ-010 in_ready  output  1  stage accepts an entry this cycle.
REQ-011 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-012 in_data  input  DATA_W  upstream data bundle.
REQ-013 out_valid  output  1  downstream entry offered.
REQ-014 out_ready  input  1  downstream accepts (deasserted = stall).
REQ-015 out_ctrl  output  CTRL_W  control bundle, forced to all-zero whenever out_valid=0.
REQ-016 out_data  output  DATA_W  data bundle, don't-care whenever out_valid=0.
REQ-017 bubble_cnt  output  CNT_W  cycles with out_valid=0.
REQ-018 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-019 An input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1; an output transfer when out_valid=1 and out_ready=1.
REQ-020 Entries SHALL leave in strict arrival order; none duplicated or lost except by flush/reset.
REQ-021 SKID=1 SHALL implement states EMPTY, ONE (main full), TWO (main+skid full); out_* driven from main entry.
REQ-022 SKID=1 in_ready SHALL be a registered function of state only: 1 in EMPTY/ONE, 0 in TWO (no combinational out_ready->in_ready path).
REQ-023 SKID=1 transitions: EMPTY+in->ONE; ONE+in+no out->TWO (entry into skid); ONE+out+no in->EMPTY; ONE+in+out->ONE (new entry into main); TWO+out->ONE (skid moves to main); otherwise hold.
REQ-024 SKID=0 SHALL hold one entry, in_ready = out_ready OR NOT out_valid (combinational), latency 1 cycle.
REQ-025 Latency from input transfer to out_valid SHALL be 1 cycle in both modes when the stage is empty.
REQ-026 While out_valid=1 and out_ready=0, out_ctrl/out_data SHALL remain stable.
REQ-027 flush=1 SHALL, at the next edge, force state EMPTY (SKID=1) or out_valid=0 (SKID=0), taking priority over any simultaneous input or output transfer; an input offered in the flush cycle is dropped.
REQ-028 out_ctrl SHALL read all-zero in the cycle after flush, so a bubble never asserts a write/branch control.
REQ-029 bubble_cnt SHALL increment by 1 each non-reset cycle with out_valid=0, saturating at 2^CNT_W-1.
REQ-030 stall_cnt SHALL increment by 1 each non-reset cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
REQ-031 flush SHALL NOT clear either counter.

Reset
REQ-032 reset=1 at an edge SHALL set state EMPTY, out_valid=0, out_ctrl=0, bubble_cnt=0, stall_cnt=0; in_ready=1 (SKID=1) from the following cycle.
REQ-033 reset SHALL take priority over flush and all transfers, including when asserted with the stage in TWO.
REQ-034 Held data registers need not be reset; only valid/state/counters are.

Verification
REQ-035 SKID=1, out_ready=1, in_valid=1 streaming 0x1..0x8 -> out_data 0x1..0x8 one per cycle, 1-cycle latency, in_ready stays 1.
REQ-036 SKID=1, push 0xA,0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA stable, stall_cnt counts; raise out_ready -> 0xA then 0xB, in_ready=1 after first pop.
REQ-037 In TWO, flush=1 with in_valid=1 in_ctrl=3'b111 -> next cycle out_valid=0, out_ctrl=3'b000, in_ready=1, counters unchanged by flush.
REQ-038 SKID=0, out_ready toggling 1,0,1 with continuous input -> in_ready mirrors out_ready while full, no entry lost or duplicated.
REQ-039 CNT_W=4, hold in_valid=0 for 20 cycles after reset -> bubble_cnt reaches 15 and holds.
REQ-040 reset asserted mid-stream in TWO -> next cycle out_valid=0, out_ctrl=0, both counters 0, stream restarts cleanly.
